exe_arbiter: RTL and testbench

EXE_ARBITER -- requirements
Module: exe_arbiter

---
 rtl/exe_arb_pkg.sv | 34 +++
 rtl/exe_arbiter_exe_unit.sv | 60 ++++++
 rtl/exe_arbiter.sv | 136 +++++++++++++
 tb/tb_exe_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/exe_arb_pkg.sv
// exe_arb_pkg -- shared definitions for the exe_arbiter slice.
//   EXE_M / EXE_N : default operand and opcode widths
//   NREQ          : number of requesters sharing the exe unit
//   state_e       : arbiter FSM states
//   OF/SF/BF/VF   : bit positions inside the 4-bit flag word
//   OP_*          : opcodes understood by exe_unit_rtl_2
package exe_arb_pkg;
  localparam int EXE_M = 8;
  localparam int EXE_N = 4;
  localparam int NREQ  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Flag word layout: {VF,BF,SF,OF}
  localparam int OF = 0;  // signed overflow (add/sub)
  localparam int SF = 1;  // sign of result
  localparam int BF = 2;  // carry / borrow / shifted-out bit
  localparam int VF = 3;  // opcode recognised

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOT = 5;
  localparam int OP_SHL = 6;
  localparam int OP_SHR = 7;
  localparam int OP_PSB = 8;
endpackage

// File: rtl/exe_arbiter_exe_unit.sv
// exe_unit_rtl_2 -- combinational execution unit shared by the arbiter.
//   i_oper  [N-1:0] : opcode (OP_* in exe_arb_pkg); unknown codes give 0, VF=0
//   i_a/i_b [M-1:0] : operands
//   o_res   [M-1:0] : result
//   o_flags [3:0]   : {VF,BF,SF,OF}
module exe_unit_rtl_2
  import exe_arb_pkg::*;
#(
  parameter int M = EXE_M,
  parameter int N = EXE_N
) (
  input  logic [N-1:0] i_oper,
  input  logic [M-1:0] i_a,
  input  logic [M-1:0] i_b,
  output logic [M-1:0] o_res,
  output logic [3:0]   o_flags
);
  // One spare bit on top catches carry/borrow and the SHL shifted-out bit.
  logic [M:0] wide;
  logic       bf, ovf, vf;

  always_comb begin
    wide = '0;
    bf   = 1'b0;
    ovf  = 1'b0;
    vf   = 1'b1;
    case (i_oper)
      N'(OP_ADD): begin
        wide = {1'b0, i_a} + {1'b0, i_b};
        bf   = wide[M];
        ovf  = (i_a[M-1] == i_b[M-1]) && (wide[M-1] != i_a[M-1]);
      end
      N'(OP_SUB): begin
        wide = {1'b0, i_a} - {1'b0, i_b};
        bf   = wide[M];  // set when a < b (unsigned)
        ovf  = (i_a[M-1] != i_b[M-1]) && (wide[M-1] != i_a[M-1]);
      end
      N'(OP_AND): wide = {1'b0, i_a & i_b};
      N'(OP_OR):  wide = {1'b0, i_a | i_b};
      N'(OP_XOR): wide = {1'b0, i_a ^ i_b};
      N'(OP_NOT): wide = {1'b0, ~i_a};
      N'(OP_SHL): begin
        wide = {i_a, 1'b0};
        bf   = i_a[M-1];
      end
      N'(OP_SHR): begin
        wide = {2'b00, i_a[M-1:1]};
        bf   = i_a[0];
      end
      N'(OP_PSB): wide = {1'b0, i_b};
      default:    vf = 1'b0;
    endcase
    o_res       = wide[M-1:0];
    o_flags     = '0;
    o_flags[OF] = ovf;
    o_flags[SF] = wide[M-1];
    o_flags[BF] = bf;
    o_flags[VF] = vf;
  end
endmodule

// File: rtl/exe_arbiter.sv
// exe_arbiter -- shares one exe_unit_rtl_2 between two requesters,
// one transaction at a time: IDLE -> LOAD (grant, capture) -> EXEC
// (compute, register result) -> DONE (done pulse) -> IDLE.
//   i_clk_p, i_rst_n (sync, active-low)
//   i_req[1:0], i_oper[2N-1:0], i_argA/i_argB[2M-1:0] : per-port request + operands
//   o_gnt[1:0]  : one-hot, high during LOAD
//   o_done[1:0] : one-hot, high during DONE
//   o_result, o_flags : last completed transaction, held until next EXEC end
//   o_busy      : state != IDLE
// Build option: define EXE_ARB_RR_EN for round-robin arbitration; otherwise
// port 0 has fixed priority and no pointer register exists.
module exe_arbiter
  import exe_arb_pkg::*;
#(
  parameter int M = EXE_M,
  parameter int N = EXE_N
) (
  input  logic                 i_clk_p,
  input  logic                 i_rst_n,
  input  logic [NREQ-1:0]      i_req,
  input  logic [NREQ*N-1:0]    i_oper,
  input  logic [NREQ*M-1:0]    i_argA,
  input  logic [NREQ*M-1:0]    i_argB,
  output logic [NREQ-1:0]      o_gnt,
  output logic [NREQ-1:0]      o_done,
  output logic [M-1:0]         o_result,
  output logic [3:0]           o_flags,
  output logic                 o_busy
);
  state_e       state_q, state_d;
  logic         win_q, win_d;
  logic [N-1:0] oper_q, oper_d;
  logic [M-1:0] a_q, a_d, b_q, b_d;
  logic [M-1:0] result_q, result_d;
  logic [3:0]   flags_q, flags_d;
  logic         pick;
  logic [M-1:0] eu_res;
  logic [3:0]   eu_flags;

`ifdef EXE_ARB_RR_EN
  // Port that gets priority on a tie; flips to the other port after each
  // completed transaction, so aborts do not disturb fairness.
  logic ptr_q, ptr_d;
  always_comb pick = (i_req[0] && i_req[1]) ? ptr_q : i_req[1];
`else
  always_comb pick = ~i_req[0];
`endif

  exe_unit_rtl_2 #(.M(M), .N(N)) u_exe (
    .i_oper  (oper_q),
    .i_a     (a_q),
    .i_b     (b_q),
    .o_res   (eu_res),
    .o_flags (eu_flags)
  );

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    oper_d   = oper_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    flags_d  = flags_q;
`ifdef EXE_ARB_RR_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|i_req) begin
          win_d   = pick;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // Winner withdrew before capture: abort without side effects.
        if (i_req[win_q]) begin
          oper_d  = i_oper[int'(win_q)*N +: N];
          a_d     = i_argA[int'(win_q)*M +: M];
          b_d     = i_argB[int'(win_q)*M +: M];
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d = eu_res;
        flags_d  = eu_flags;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
`ifdef EXE_ARB_RR_EN
        ptr_d   = ~win_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_p) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      win_q    <= 1'b0;
      oper_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      flags_q  <= '0;
`ifdef EXE_ARB_RR_EN
      ptr_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      oper_q   <= oper_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      flags_q  <= flags_d;
`ifdef EXE_ARB_RR_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Grant and done decode from distinct states, so they can never overlap.
  always_comb begin
    o_gnt  = (state_q == ST_LOAD) ? (NREQ'(1) << win_q) : '0;
    o_done = (state_q == ST_DONE) ? (NREQ'(1) << win_q) : '0;
  end

  assign o_result = result_q;
  assign o_flags  = flags_q;
  assign o_busy   = (state_q != ST_IDLE);
endmodule

// File: tb/tb_exe_arbiter.sv
module tb_exe_arbiter;
  localparam int M = 8;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req;
  logic [2*N-1:0] oper;
  logic [2*M-1:0] arga, argb;
  logic [1:0]     gnt, done;
  logic [M-1:0]   result;
  logic [3:0]     flags;
  logic           busy;

  int errs   = 0;
  int checks = 0;

  // Reference state: last completed result/flags and tie-break port.
  logic [7:0] exp_res;
  logic [3:0] exp_flg;
  int         prio;

  always #5 clk = ~clk;

  exe_arbiter #(.M(M), .N(N)) dut (
    .i_clk_p (clk),
    .i_rst_n (rst_n),
    .i_req   (req),
    .i_oper  (oper),
    .i_argA  (arga),
    .i_argB  (argb),
    .o_gnt   (gnt),
    .o_done  (done),
    .o_result(result),
    .o_flags (flags),
    .o_busy  (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural ALU: returns {VF,BF,SF,OF,result[7:0]}.
  function automatic logic [11:0] alu(input int op, input int a, input int b);
    int r, sa, sb, s;
    bit bf, ovf, vf;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    bf = 0; ovf = 0; vf = 1; r = 0;
    case (op)
      0: begin r = a + b; bf = (r > 255); s = sa + sb; ovf = (s > 127) || (s < -128); end
      1: begin r = a - b; bf = (a < b);   s = sa - sb; ovf = (s > 127) || (s < -128); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: begin r = a * 2; bf = (a >= 128); end
      7: begin r = a / 2; bf = (a % 2) == 1; end
      8: r = b;
      default: begin r = 0; vf = 0; end
    endcase
    r = r & 255;
    return {vf, bf, (r >= 128), ovf, 8'(r)};
  endfunction

  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) begin
`ifdef EXE_ARB_RR_EN
      return prio;
`else
      return 0;
`endif
    end
    return r[1] ? 1 : 0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_gnt"}, gnt, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_flg"}, flags, exp_flg);
  endtask

  // One transaction from IDLE back to IDLE; a_exec replaces argA while in EXEC.
  task automatic txn(input string tag, input logic [1:0] r, input logic [2*N-1:0] op,
                     input logic [2*M-1:0] av, input logic [2*M-1:0] bv,
                     input logic [2*M-1:0] a_exec, input bit abort);
    int w;
    logic [11:0] m;
    req = r; oper = op; arga = av; argb = bv;
    w = pick(r);
    tick();  // LOAD
    chk({tag, "_gnt_load"}, gnt, 1 << w);
    chk({tag, "_done_load"}, done, 0);
    chk({tag, "_busy_load"}, busy, 1);
    if (abort) begin
      req = 2'b00;
      tick();
      chk_idle({tag, "_abort"});
      return;
    end
    m = alu(int'(oper[w*N +: N]), int'(arga[w*M +: M]), int'(argb[w*M +: M]));
    tick();  // EXEC
    arga = a_exec; argb = 16'($urandom); oper = 8'($urandom);
    chk({tag, "_gnt_exec"}, gnt, 0);
    chk({tag, "_done_exec"}, done, 0);
    tick();  // DONE
    exp_res = m[7:0]; exp_flg = m[11:8];
    chk({tag, "_done"}, done, 1 << w);
    chk({tag, "_gnt_done"}, gnt, 0);
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_flg"}, flags, exp_flg);
    prio = (w == 0) ? 1 : 0;
    req = 2'b00;
    tick();
    chk_idle({tag, "_end"});
  endtask

  initial begin
    int w;
    logic [11:0] m;
    rst_n = 1'b0; req = '0; oper = '0; arga = '0; argb = '0;
    exp_res = '0; exp_flg = '0; prio = 0;
    tick(); tick();
    chk_idle("reset");
    rst_n = 1'b1;
    tick();

    // Basic add on port 0: 5 + 3.
    txn("p0_add", 2'b01, 8'h00, 16'h0005, 16'h0003, 16'h0005, 1'b0);
    // Operand change during EXEC must not leak into the result.
    txn("p0_hold", 2'b01, 8'h01, 16'h0005, 16'h0003, 16'h00FF, 1'b0);
    // Port 1 withdraws in LOAD.
    txn("p1_abort", 2'b10, 8'h20, 16'h7700, 16'h1100, 16'h0000, 1'b1);

    // Port 1 raises request during port 0 EXEC; served only after IDLE.
    req = 2'b01; oper = 8'h00; arga = 16'h0081; argb = 16'h0080;
    tick();  // LOAD p0
    chk("late_gnt0", gnt, 2'b01);
    tick();  // EXEC p0
    req = 2'b10; oper = 8'h10; arga = 16'hC300; argb = 16'h5A00;
    m = alu(0, 'h81, 'h80);
    chk("late_exec_gnt", gnt, 0);
    tick();  // DONE p0
    exp_res = m[7:0]; exp_flg = m[11:8]; prio = 1;
    chk("late_done0", done, 2'b01);
    chk("late_gnt_done", gnt, 0);
    chk("late_res0", result, exp_res);
    chk("late_flg0", flags, exp_flg);
    tick();  // IDLE
    chk("late_idle_gnt", gnt, 0);
    chk("late_idle_busy", busy, 0);
    tick();  // LOAD p1
    chk("late_gnt1", gnt, 2'b10);
    m = alu(1, 'hC3, 'h5A);
    tick(); tick();  // DONE p1
    exp_res = m[7:0]; exp_flg = m[11:8]; prio = 0;
    chk("late_done1", done, 2'b10);
    chk("late_res1", result, exp_res);
    chk("late_flg1", flags, exp_flg);
    req = 2'b00;
    tick();

    // Continuous demand from both ports for 16 cycles.
    req = 2'b11; oper = 8'h40; arga = 16'h3C5A; argb = 16'h0FF0;
    w = 0; m = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k % 4 == 0) begin
        w = pick(2'b11);
        m = alu(int'(oper[w*N +: N]), int'(arga[w*M +: M]), int'(argb[w*M +: M]));
        chk($sformatf("cont_gnt%0d", k), gnt, 1 << w);
      end else begin
        chk($sformatf("cont_gnt%0d", k), gnt, 0);
      end
      if (k % 4 == 2) begin
        exp_res = m[7:0]; exp_flg = m[11:8];
        prio = (w == 0) ? 1 : 0;
        chk($sformatf("cont_done%0d", k), done, 1 << w);
        chk($sformatf("cont_res%0d", k), result, exp_res);
      end else begin
        chk($sformatf("cont_done%0d", k), done, 0);
      end
    end
    req = 2'b00;
    tick();

    // Reset pulse during EXEC discards the transaction.
    req = 2'b01; oper = 8'h00; arga = 16'h0010; argb = 16'h0020;
    tick(); tick();  // EXEC
    rst_n = 1'b0;
    tick();
    exp_res = '0; exp_flg = '0; prio = 0;
    chk_idle("rst_exec");
    rst_n = 1'b1; req = 2'b00;
    tick();
    chk_idle("rst_after");

    // Randomised transactions.
    for (int i = 0; i < 30; i++) begin
      txn($sformatf("rnd%0d", i), 2'($urandom_range(1, 3)),
          {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))},
          16'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 5) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
